// File: rtl/multicycle_ctrl_if.sv
// Control bundle between the multi-cycle MIPS controller and its datapath.
// master = controller side (reads IR opcode / memory ready, drives enables),
// slave  = datapath side.
interface multicycle_ctrl_if;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       pc_write;
  logic       pc_write_cond;
  logic       iord;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic       mem_to_reg;
  logic       reg_dst;
  logic       reg_write;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic [1:0] pc_source;
  logic       instr_done;
  logic       illegal_op;
  logic [3:0] state;

  modport master (
    input  opcode, mem_ready,
    output pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
           mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
           pc_source, instr_done, illegal_op, state
  );

  modport slave (
    output opcode, mem_ready,
    input  pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
           mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
           pc_source, instr_done, illegal_op, state
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Moore control FSM for a multi-cycle MIPS datapath (shared memory, single
// ALU, IR/MDR/A/B/ALUOut holding registers).
// Optional build macro MC_MEM_WAIT_EN: FETCH/MEMRD/MEMWR stall on mem_ready.
// Without it mem_ready is ignored and every memory state lasts one cycle.
module multicycle_ctrl (
  input  logic                   clk,
  input  logic                   rst,
  multicycle_ctrl_if.master      bus
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_IMMEX  = 4'd10,
    S_IMMWB  = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       instr_done;
    logic       illegal_op;
  } ctl_t;

  state_t st, nxt;
  logic   is_ori;   // IMMEX needs the ori decision after opcode stops being sampled
  logic   mem_ok;   // memory access completes this cycle
  logic   op_legal;
  ctl_t   ctl, ctl_q;

`ifdef MC_MEM_WAIT_EN
  assign mem_ok = bus.mem_ready;
`else
  logic unused_mem_ready;
  assign unused_mem_ready = bus.mem_ready;
  assign mem_ok = 1'b1;
`endif

  // Supported opcode set, consulted in DECODE only
  always_comb begin
    case (bus.opcode)
      OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_J,
      OP_ADDI, OP_ADDIU, OP_ANDI, OP_ORI, OP_LUI: op_legal = 1'b1;
      default:                                    op_legal = 1'b0;
    endcase
  end

  // Next-state selection; unreachable codes fall back to FETCH
  always_comb begin
    nxt = S_FETCH;
    case (st)
      S_FETCH:  nxt = mem_ok ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (bus.opcode)
          OP_LW, OP_SW: nxt = S_MEMADR;
          OP_RTYPE:     nxt = S_EXEC;
          OP_BEQ:       nxt = S_BRANCH;
          OP_J:         nxt = S_JUMP;
          OP_ADDI, OP_ADDIU, OP_ANDI, OP_ORI, OP_LUI: nxt = S_IMMEX;
          default:      nxt = S_FETCH;
        endcase
      end
      S_MEMADR: nxt = (bus.opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  nxt = mem_ok ? S_MEMWB : S_MEMRD;
      S_MEMWB:  nxt = S_FETCH;
      S_MEMWR:  nxt = mem_ok ? S_FETCH : S_MEMWR;
      S_EXEC:   nxt = S_ALUWB;
      S_ALUWB:  nxt = S_FETCH;
      S_BRANCH: nxt = S_FETCH;
      S_JUMP:   nxt = S_FETCH;
      S_IMMEX:  nxt = S_IMMWB;
      S_IMMWB:  nxt = S_FETCH;
      default:  nxt = S_FETCH;
    endcase
  end

  // State register plus the ori flag captured while the opcode is in DECODE
  always_ff @(posedge clk) begin
    if (rst) begin
      st     <= S_FETCH;
      is_ori <= 1'b0;
    end else begin
      st <= nxt;
      if (st == S_DECODE)
        is_ori <= (bus.opcode == OP_ORI);
    end
  end

  // Moore decode of the datapath controls. Only mem_ready (stall qualify)
  // and, in DECODE, the opcode (illegal_op) reach the outputs directly.
  always_comb begin
    ctl = '0;
    case (st)
      S_FETCH: begin
        ctl.mem_read  = 1'b1;
        ctl.ir_write  = mem_ok;
        ctl.pc_write  = mem_ok;
        ctl.alu_src_b = 2'b01;
      end
      S_DECODE: begin
        ctl.alu_src_b  = 2'b11;
        ctl.illegal_op = ~op_legal;
      end
      S_MEMADR: begin
        ctl.alu_src_a = 1'b1;
        ctl.alu_src_b = 2'b10;
      end
      S_MEMRD: begin
        ctl.mem_read = 1'b1;
        ctl.iord     = 1'b1;
      end
      S_MEMWB: begin
        ctl.reg_write  = 1'b1;
        ctl.mem_to_reg = 1'b1;
        ctl.instr_done = 1'b1;
      end
      S_MEMWR: begin
        ctl.mem_write  = 1'b1;
        ctl.iord       = 1'b1;
        ctl.instr_done = mem_ok;
      end
      S_EXEC: begin
        ctl.alu_src_a = 1'b1;
        ctl.alu_op    = 2'b10;
      end
      S_ALUWB: begin
        ctl.reg_write  = 1'b1;
        ctl.reg_dst    = 1'b1;
        ctl.instr_done = 1'b1;
      end
      S_BRANCH: begin
        ctl.alu_src_a     = 1'b1;
        ctl.alu_op        = 2'b01;
        ctl.pc_write_cond = 1'b1;
        ctl.pc_source     = 2'b01;
        ctl.instr_done    = 1'b1;
      end
      S_JUMP: begin
        ctl.pc_write   = 1'b1;
        ctl.pc_source  = 2'b10;
        ctl.instr_done = 1'b1;
      end
      S_IMMEX: begin
        ctl.alu_src_a = 1'b1;
        ctl.alu_src_b = 2'b10;
        ctl.alu_op    = is_ori ? 2'b11 : 2'b00;
      end
      S_IMMWB: begin
        ctl.reg_write  = 1'b1;
        ctl.instr_done = 1'b1;
      end
      default: ctl = '0;
    endcase
  end

  // Everything, including pc_write/ir_write, is held low during reset
  assign ctl_q = rst ? '0 : ctl;

  assign bus.pc_write      = ctl_q.pc_write;
  assign bus.pc_write_cond = ctl_q.pc_write_cond;
  assign bus.iord          = ctl_q.iord;
  assign bus.mem_read      = ctl_q.mem_read;
  assign bus.mem_write     = ctl_q.mem_write;
  assign bus.ir_write      = ctl_q.ir_write;
  assign bus.mem_to_reg    = ctl_q.mem_to_reg;
  assign bus.reg_dst       = ctl_q.reg_dst;
  assign bus.reg_write     = ctl_q.reg_write;
  assign bus.alu_src_a     = ctl_q.alu_src_a;
  assign bus.alu_src_b     = ctl_q.alu_src_b;
  assign bus.alu_op        = ctl_q.alu_op;
  assign bus.pc_source     = ctl_q.pc_source;
  assign bus.instr_done    = ctl_q.instr_done;
  assign bus.illegal_op    = ctl_q.illegal_op;
  assign bus.state         = rst ? 4'd0 : st;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: directed reset/instruction
// sequences followed by randomized instruction streams, checked against a
// per-instruction reference model (state path, per-state controls, CPI).
module tb_multicycle_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  multicycle_ctrl_if bus ();
  multicycle_ctrl dut (.clk(clk), .rst(rst), .bus(bus.master));

`ifdef MC_MEM_WAIT_EN
  localparam bit WAITM = 1'b1;
`else
  localparam bit WAITM = 1'b0;
`endif

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       instr_done;
    logic       illegal_op;
  } ctl_t;

  int checks = 0;
  int errors = 0;
  int n_cyc, n_done, n_ir, n_ill, n_rw, n_mw, total_cyc;

  logic [5:0] pool [10] = '{6'b100011, 6'b101011, 6'b000000, 6'b000100,
                            6'b000010, 6'b001000, 6'b001001, 6'b001100,
                            6'b001101, 6'b001111};

  function automatic bit legal(input logic [5:0] op);
    foreach (pool[i]) if (pool[i] == op) return 1'b1;
    return 1'b0;
  endfunction

  // Cycles per instruction with no wait states
  function automatic int cpi(input logic [5:0] op);
    case (op)
      6'b100011:                                    return 5;
      6'b101011, 6'b000000:                         return 4;
      6'b001000, 6'b001001, 6'b001100, 6'b001101,
      6'b001111:                                    return 4;
      6'b000100, 6'b000010:                         return 3;
      default:                                      return 2;
    endcase
  endfunction

  function automatic ctl_t observe();
    ctl_t o;
    o.pc_write = bus.pc_write;   o.pc_write_cond = bus.pc_write_cond;
    o.iord = bus.iord;           o.mem_read = bus.mem_read;
    o.mem_write = bus.mem_write; o.ir_write = bus.ir_write;
    o.mem_to_reg = bus.mem_to_reg; o.reg_dst = bus.reg_dst;
    o.reg_write = bus.reg_write; o.alu_src_a = bus.alu_src_a;
    o.alu_src_b = bus.alu_src_b; o.alu_op = bus.alu_op;
    o.pc_source = bus.pc_source; o.instr_done = bus.instr_done;
    o.illegal_op = bus.illegal_op;
    return o;
  endfunction

  // Expected controls for a step of instruction op; rdy matters only for
  // memory steps when waits are enabled.
  function automatic ctl_t expect_ctl(input int s, input logic [5:0] op, input bit rdy);
    ctl_t e;
    bit   ok;
    e  = '0;
    ok = WAITM ? rdy : 1'b1;
    case (s)
      0:  begin e.mem_read = 1; e.ir_write = ok; e.pc_write = ok; e.alu_src_b = 2'b01; end
      1:  begin e.alu_src_b = 2'b11; e.illegal_op = !legal(op); end
      2:  begin e.alu_src_a = 1; e.alu_src_b = 2'b10; end
      3:  begin e.mem_read = 1; e.iord = 1; end
      4:  begin e.reg_write = 1; e.mem_to_reg = 1; e.instr_done = 1; end
      5:  begin e.mem_write = 1; e.iord = 1; e.instr_done = ok; end
      6:  begin e.alu_src_a = 1; e.alu_op = 2'b10; end
      7:  begin e.reg_write = 1; e.reg_dst = 1; e.instr_done = 1; end
      8:  begin e.alu_src_a = 1; e.alu_op = 2'b01; e.pc_write_cond = 1;
                e.pc_source = 2'b01; e.instr_done = 1; end
      9:  begin e.pc_write = 1; e.pc_source = 2'b10; e.instr_done = 1; end
      10: begin e.alu_src_a = 1; e.alu_src_b = 2'b10;
                e.alu_op = (op == 6'b001101) ? 2'b11 : 2'b00; end
      11: begin e.reg_write = 1; e.instr_done = 1; end
      default: e = '0;
    endcase
    return e;
  endfunction

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock cycle: entered just after a negedge, drives inputs, checks, and
  // returns at the following negedge.
  task automatic cyc(input int s, input logic [5:0] op_in, input bit rdy, input logic [5:0] op);
    ctl_t got, exp;
    bus.opcode    = op_in;
    bus.mem_ready = rdy;
    #1;
    got = observe();
    exp = expect_ctl(s, op, rdy);
    check_vec($sformatf("state(op=%b)", op), 32'(bus.state), 32'(s));
    check_vec($sformatf("ctl(op=%b,s=%0d)", op, s), 32'(got), 32'(exp));
    n_cyc++; total_cyc++;
    n_done += got.instr_done;
    n_ir   += got.ir_write;
    n_ill  += got.illegal_op;
    n_rw   += got.reg_write;
    n_mw   += got.mem_write;
    @(negedge clk);
  endtask

  // Run one instruction through the model: state path from the opcode,
  // with sf stall cycles in FETCH and sm in MEMRD/MEMWR when waits exist.
  task automatic run_instr(input logic [5:0] op, input int sf, input int sm);
    int seq[$];
    int stalls, extra;
    logic [5:0] drv;
    seq = '{0, 1};
    case (op)
      6'b100011: seq = '{0, 1, 2, 3, 4};
      6'b101011: seq = '{0, 1, 2, 5};
      6'b000000: seq = '{0, 1, 6, 7};
      6'b000100: seq = '{0, 1, 8};
      6'b000010: seq = '{0, 1, 9};
      default: if (legal(op)) seq = '{0, 1, 10, 11};
    endcase
    n_cyc = 0; n_done = 0; n_ir = 0; n_ill = 0; n_rw = 0; n_mw = 0;
    extra = 0;
    foreach (seq[i]) begin
      // opcode only matters in DECODE/MEMADR; feed junk elsewhere
      drv = (seq[i] == 1 || seq[i] == 2) ? op : 6'($urandom);
      if (WAITM && (seq[i] == 0 || seq[i] == 3 || seq[i] == 5)) begin
        stalls = (seq[i] == 0) ? sf : sm;
        extra += stalls;
        repeat (stalls) cyc(seq[i], drv, 1'b0, op);
        cyc(seq[i], drv, 1'b1, op);
      end else begin
        cyc(seq[i], drv, 1'($urandom), op);
      end
    end
    check_vec($sformatf("cycles(op=%b)", op), 32'(n_cyc), 32'(cpi(op) + extra));
    check_vec($sformatf("instr_done(op=%b)", op), 32'(n_done), 32'(legal(op) ? 1 : 0));
    check_vec($sformatf("ir_write(op=%b)", op), 32'(n_ir), 32'd1);
    check_vec($sformatf("illegal_op(op=%b)", op), 32'(n_ill), 32'(legal(op) ? 0 : 1));
    if (!legal(op))
      check_vec("illegal_no_write", 32'(n_rw + n_mw), 32'd0);
  endtask

  initial begin
    logic [5:0] op;
    rst = 1'b1;
    bus.opcode = 6'b100011;
    bus.mem_ready = 1'b0;
    total_cyc = 0;
    @(negedge clk);
    // reset held for 3 cycles: everything quiet, state 0
    repeat (3) begin
      bus.opcode = 6'($urandom);
      bus.mem_ready = 1'($urandom);
      #1;
      check_vec("reset_state", 32'(bus.state), 32'd0);
      check_vec("reset_ctl", 32'(observe()), 32'd0);
      @(negedge clk);
    end
    rst = 1'b0;

    // lw directly after reset (first cycle is FETCH)
    run_instr(6'b100011, 0, 0);

    // R-type, sw, beq, j back to back
    total_cyc = 0;
    run_instr(6'b000000, 0, 0);
    run_instr(6'b101011, 0, 0);
    run_instr(6'b000100, 0, 0);
    run_instr(6'b000010, 0, 0);
    check_vec("seq_total_cycles", 32'(total_cyc), 32'd14);

    // ori then addi, then an illegal opcode
    run_instr(6'b001101, 0, 0);
    run_instr(6'b001000, 0, 0);
    run_instr(6'b111111, 0, 0);

    // reset in the middle of a lw, during MEMRD
    n_cyc = 0;
    cyc(0, 6'($urandom), 1'b1, 6'b100011);
    cyc(1, 6'b100011, 1'b1, 6'b100011);
    cyc(2, 6'b100011, 1'b1, 6'b100011);
    rst = 1'b1;
    #1;
    check_vec("midreset_state", 32'(bus.state), 32'd0);
    check_vec("midreset_ctl", 32'(observe()), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    run_instr(6'b000000, 0, 0);

    // lw with 3 stall cycles in FETCH and MEMRD (11 cycles with waits)
    run_instr(6'b100011, 3, 3);

    // randomized instruction stream
    for (int k = 0; k < 60; k++) begin
      if ($urandom_range(0, 4) == 0) op = 6'($urandom);
      else op = pool[$urandom_range(0, 9)];
      run_instr(op, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
